tape_player: RTL and testbench

//  Replays a tape dump as a Vector-06C tape signal into PPI1 port C bit 4 (tapein), replacing the tied-off tapein.
//  The host pushes bytes into an internal FIFO via an ioctl-style strobe.
//  The block frames the stream with pilot and sync, phase-encodes every bit and drives a single-bit line.

---
 rtl/tape_pkg.sv | 28 ++
 rtl/tape_fifo.sv | 74 +++++++
 rtl/tape_player.sv | 177 +++++++++++++++++
 tb/tb_tape_player.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the Vector-06C tape player.
// Contents:
//   tape_state_t  playback FSM states
//   TAPE_SYNC     sync byte sent between the pilot and the data
//   TAPE_PILOT    filler byte used for the pilot and the trailing byte
//   half_level    line level for one half-bit of a byte
package tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PILOT,
        SYNC,
        DATA,
        STALL,
        TAIL
    } tape_state_t;

    localparam logic [7:0] TAPE_SYNC  = 8'hE6;
    localparam logic [7:0] TAPE_PILOT = 8'h00;

    // Half-bit h of byte b, MSB first: the even half carries ~bit and the odd half carries bit.
    function automatic logic half_level(input logic [7:0] b, input logic [3:0] h);
        logic bit_v;
        bit_v = b[3'd7 - h[3:1]];
        return h[0] ? bit_v : ~bit_v;
    endfunction

endpackage

// File: rtl/tape_fifo.sv
// Synchronous byte FIFO that buffers host data for the tape player.
// Ports:
//   clk_sys  system clock
//   reset    async active-high reset; empties the FIFO
//   flush    sync clear of pointers and count
//   din      byte to write
//   push     write request; accepted when not full, or when full and popping in the same cycle
//   pop      read request; dout holds the head byte
//   dout     head of the FIFO; equals din while empty, so push+pop on empty passes it through
//   full     2**FIFO_AW bytes stored
//   empty    no bytes stored
module tape_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       flush,
    input  logic [7:0] din,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (FIFO_AW + 1)'(DEPTH));
        pop_ok  = pop & (~empty | push);
        // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
        push_ok = push & (~full | pop_ok);
        dout    = empty ? din : mem[rptr];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + FIFO_AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (FIFO_AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (FIFO_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok && !flush) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/tape_player.sv
// Replays a host-supplied tape dump as a phase-encoded Vector-06C tape signal.
// The host fills a byte FIFO; on a play edge the block is framed as pilot bytes, one sync byte,
// the FIFO data and one trailing byte. Drives PPI1 port C[4] as ipc({~kbd_shift, tapein, 4'b1111}).
// Ports:
//   clk_sys     system clock
//   reset       async active-high reset; clears all state
//   din         byte to enqueue
//   din_wr      one-cycle push strobe, accepted in every state
//   eof         level: the host has pushed the last byte of the block
//   play        rising edge starts playback from IDLE
//   stop        level: abort playback, flush the FIFO, return to IDLE
//   fifo_full   FIFO full
//   fifo_empty  FIFO empty
//   busy        playback in progress
//   underrun    sticky: the FIFO ran dry at a byte boundary without eof
//   tapein      tape line level
module tape_player
    import tape_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned HALF_DIV    = 32000,
    parameter int unsigned PILOT_BYTES = 256
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_wr,
    input  logic       eof,
    input  logic       play,
    input  logic       stop,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       busy,
    output logic       underrun,
    output logic       tapein
);

    localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned PW = $clog2(PILOT_BYTES + 1);

    tape_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hidx_q, hidx_d;
    logic [7:0]    sr_q, sr_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          underrun_q, underrun_d;
    logic          play_q;

    logic       play_rise;
    logic       tick;
    logic       byte_end;
    logic       fifo_pop;
    logic [7:0] fifo_dout;

    tape_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (stop),
        .din     (din),
        .push    (din_wr),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign play_rise = play & ~play_q;
    assign tick      = (cnt_q == CW'(HALF_DIV - 1));
    assign byte_end  = tick && (hidx_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hidx_d     = hidx_q;
        sr_d       = sr_q;
        pcnt_d     = pcnt_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            hidx_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play_rise) begin
                        state_d    = PILOT;
                        cnt_d      = '0;
                        hidx_d     = '0;
                        sr_d       = TAPE_PILOT;
                        pcnt_d     = PW'(PILOT_BYTES);
                        underrun_d = 1'b0;
                    end
                end
                PILOT, SYNC, DATA, TAIL: begin
                    if (tick) begin
                        cnt_d  = '0;
                        hidx_d = hidx_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // hidx wraps to 0 and cnt to 0 at byte_end, so the next byte starts clean.
                    if (byte_end) begin
                        if (state_q == PILOT) begin
                            if (pcnt_q == PW'(1)) begin
                                state_d = SYNC;
                                sr_d    = TAPE_SYNC;
                            end else begin
                                pcnt_d = pcnt_q - PW'(1);
                                sr_d   = TAPE_PILOT;
                            end
                        end else if (state_q == TAIL) begin
                            state_d = IDLE;
                        end else if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            sr_d     = fifo_dout;
                            state_d  = DATA;
                        end else if (eof) begin
                            state_d = TAIL;
                            sr_d    = TAPE_PILOT;
                        end else begin
                            state_d    = STALL;
                            underrun_d = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sr_d     = fifo_dout;
                        state_d  = DATA;
                        cnt_d    = '0;
                        hidx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hidx_q     <= '0;
            sr_q       <= '0;
            pcnt_q     <= '0;
            underrun_q <= 1'b0;
            play_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hidx_q     <= hidx_d;
            sr_q       <= sr_d;
            pcnt_q     <= pcnt_d;
            underrun_q <= underrun_d;
            play_q     <= play;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        underrun = underrun_q;
        unique case (state_q)
            IDLE:    tapein = 1'b0;
            // The last half sent was the second half of bit 0, i.e. the bit itself.
            STALL:   tapein = sr_q[0];
            default: tapein = half_level(sr_q, hidx_q);
        endcase
    end

endmodule

// File: tb/tb_tape_player.sv
module tb_tape_player;

    localparam int HD       = 4;
    localparam int PB       = 2;
    localparam int AW       = 2;
    localparam int BYTE_CYC = 16 * HD;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_wr;
    logic       eof;
    logic       play;
    logic       stop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       busy;
    logic       underrun;
    logic       tapein;

    tape_player #(
        .FIFO_AW     (AW),
        .HALF_DIV    (HD),
        .PILOT_BYTES (PB)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .din        (din),
        .din_wr     (din_wr),
        .eof        (eof),
        .play       (play),
        .stop       (stop),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .busy       (busy),
        .underrun   (underrun),
        .tapein     (tapein)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_bit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, want, cyc);
        end
    endtask

    // Reference line level: MSB first, first half ~bit, second half bit.
    function automatic logic exp_level(input logic [7:0] d, input int h);
        logic b;
        b = d[7 - h / 2];
        return (h % 2 == 0) ? ~b : b;
    endfunction

    // Monitor: each expected byte owns 64 consecutive cycles starting at its start cycle.
    initial begin : monitor
        exp_t it;
        int   bad;
        int   first_h;
        logic first_got;
        logic want;
        forever begin
            while (exp_q.size() == 0) @(negedge clk_sys);
            it = exp_q.pop_front();
            while (cyc < it.start) @(negedge clk_sys);
            if (cyc != it.start) begin
                errors++;
                $display("FAIL byte %02h late: monitor at cyc %0d expected start %0d",
                         it.data, cyc, it.start);
            end
            bad = 0;
            first_h = 0;
            first_got = 1'b0;
            for (int h = 0; h < 16; h++) begin
                for (int j = 0; j < HD; j++) begin
                    if (h != 0 || j != 0) @(negedge clk_sys);
                    want = exp_level(it.data, h);
                    if (tapein !== want) begin
                        if (bad == 0) begin
                            first_h = h;
                            first_got = tapein;
                        end
                        bad++;
                    end
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL byte %02h @%0d: %0d samples wrong, first in half %0d got %b expected %b",
                         it.data, it.start, bad, first_h, first_got, exp_level(it.data, first_h));
            end
        end
    end

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_sys);
    endtask

    task automatic push_byte(input logic [7:0] b);
        din    = b;
        din_wr = 1'b1;
        step();
        din_wr = 1'b0;
    endtask

    task automatic enq(input logic [7:0] b, input int s);
        exp_t e;
        e.data  = b;
        e.start = s;
        exp_q.push_back(e);
    endtask

    // Pilot bytes then the sync byte; returns the cycle the first data slot begins.
    task automatic expect_preamble(input int s, output int data_c);
        for (int i = 0; i < PB; i++) enq(8'h00, s + i * BYTE_CYC);
        enq(8'hE6, s + PB * BYTE_CYC);
        data_c = s + (PB + 1) * BYTE_CYC;
    endtask

    task automatic expect_stream(input int s, input logic [7:0] payload[$], output int end_c);
        int c;
        expect_preamble(s, c);
        foreach (payload[i]) begin
            enq(payload[i], c);
            c += BYTE_CYC;
        end
        enq(8'h00, c);
        end_c = c + BYTE_CYC;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    task automatic check_done(input int end_c, input string tag);
        wait_until(end_c - 1);
        check_bit({tag, " busy last cycle"}, busy, 1'b1);
        step();
        check_bit({tag, " busy dropped"}, busy, 1'b0);
        check_bit({tag, " tapein idle"}, tapein, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int         s;
        int         end_c;
        int         p;
        int         n;
        int         flips;
        logic [7:0] b[5];
        logic [7:0] payload[$];

        reset  = 1'b1;
        din    = 8'h00;
        din_wr = 1'b0;
        eof    = 1'b0;
        play   = 1'b0;
        stop   = 1'b0;
        repeat (2) step();
        check_bit("reset tapein", tapein, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset underrun", underrun, 1'b0);
        check_bit("reset fifo_empty", fifo_empty, 1'b1);
        check_bit("reset fifo_full", fifo_full, 1'b0);
        reset = 1'b0;
        repeat (2) step();

        // 1: single byte with eof
        eof = 1'b1;
        push_byte(8'hA5);
        check_bit("t1 not empty", fifo_empty, 1'b0);
        s = cyc + 1;
        payload = {8'hA5};
        expect_stream(s, payload, end_c);
        pulse_play();
        check_bit("t1 busy after play", busy, 1'b1);
        check_bit("t1 first pilot half", tapein, 1'b1);
        check_int("t1 frame length", end_c - s, 320);
        check_done(end_c, "t1");
        check_bit("t1 underrun", underrun, 1'b0);

        // 2: overfill depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
            if (i == 2) check_bit("t2 not full at 3", fifo_full, 1'b0);
            if (i == 3) check_bit("t2 full at 4", fifo_full, 1'b1);
        end
        check_bit("t2 full after 5th", fifo_full, 1'b1);
        s = cyc + 1;
        payload = {b[0], b[1], b[2], b[3]};
        expect_stream(s, payload, end_c);
        pulse_play();
        check_done(end_c, "t2");
        check_bit("t2 empty at end", fifo_empty, 1'b1);

        // random blocks
        repeat (3) begin
            n = $urandom_range(1, 4);
            payload = {};
            for (int i = 0; i < n; i++) begin
                b[i] = 8'($urandom);
                payload.push_back(b[i]);
                push_byte(b[i]);
            end
            s = cyc + 1;
            expect_stream(s, payload, end_c);
            pulse_play();
            check_done(end_c, "rnd");
        end

        // 3: underrun stall and resume
        eof = 1'b0;
        s = cyc + 1;
        expect_preamble(s, p);
        pulse_play();
        wait_until(p);
        check_bit("t3 busy in stall", busy, 1'b1);
        check_bit("t3 underrun set", underrun, 1'b1);
        check_bit("t3 stall level", tapein, 1'b0);
        flips = 0;
        repeat (25) begin
            step();
            if (tapein !== 1'b0 || busy !== 1'b1) flips++;
        end
        check_int("t3 stall frozen", flips, 0);
        p = cyc;
        enq(8'h3C, p + 2);
        enq(8'h00, p + 2 + BYTE_CYC);
        din    = 8'h3C;
        din_wr = 1'b1;
        eof    = 1'b1;
        step();
        din_wr = 1'b0;
        check_bit("t3 still frozen", tapein, 1'b0);
        check_bit("t3 underrun sticky", underrun, 1'b1);
        check_done(p + 2 + 2 * BYTE_CYC, "t3");
        check_bit("t3 underrun after idle", underrun, 1'b1);

        // 4: stop mid-DATA, then replay from pilot
        push_byte(8'h11);
        push_byte(8'h22);
        s = cyc + 1;
        expect_preamble(s, p);
        pulse_play();
        check_bit("t4 underrun cleared by play", underrun, 1'b0);
        wait_until(p + 20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_bit("t4 stop busy", busy, 1'b0);
        check_bit("t4 stop tapein", tapein, 1'b0);
        check_bit("t4 stop flushed", fifo_empty, 1'b1);
        repeat (10) step();
        check_bit("t4 stays idle", busy, 1'b0);
        s = cyc + 1;
        payload = {};
        expect_stream(s, payload, end_c);
        pulse_play();
        check_bit("t4 replay first pilot half", tapein, 1'b1);
        check_done(end_c, "t4");

        // 5: async reset mid-byte
        push_byte(8'h5A);
        s = cyc + 1;
        for (int i = 0; i < PB; i++) enq(8'h00, s + i * BYTE_CYC);
        pulse_play();
        wait_until(s + 150);
        reset = 1'b1;
        #1;
        check_bit("t5 reset tapein", tapein, 1'b0);
        check_bit("t5 reset busy", busy, 1'b0);
        check_bit("t5 reset underrun", underrun, 1'b0);
        check_bit("t5 reset fifo_empty", fifo_empty, 1'b1);
        check_bit("t5 reset fifo_full", fifo_full, 1'b0);
        step();
        reset = 1'b0;
        flips = 0;
        repeat (100) begin
            step();
            if (tapein !== 1'b0 || busy !== 1'b0) flips++;
        end
        check_int("t5 silent after reset", flips, 0);

        // 6: push while full during a pop
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
        end
        check_bit("t6 full", fifo_full, 1'b1);
        b[4] = 8'($urandom);
        s = cyc + 1;
        payload = {b[0], b[1], b[2], b[3], b[4]};
        expect_stream(s, payload, end_c);
        pulse_play();
        wait_until(s + (PB + 1) * BYTE_CYC - 1);
        din    = b[4];
        din_wr = 1'b1;
        step();
        din_wr = 1'b0;
        check_bit("t6 still full after push+pop", fifo_full, 1'b1);
        check_done(end_c, "t6");

        repeat (4) step();
        check_int("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
